// File: rtl/ex_muldiv_unit.sv
// Multi-cycle multiply/divide unit beside the execute stage.
// result = reg2_i OP reg1_i (reg2_i = rj, reg1_i = rk). The multiply is held for MUL_CYCLES
// cycles so a retimed multiplier fits. Divides are radix-2 restoring on magnitudes, with the
// sign fix-up applied on the last iteration.
module ex_muldiv_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             cancel_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] reg1_i,
    input  logic [WIDTH-1:0] reg2_i,
    output logic [WIDTH-1:0] result_o,
    output logic             ready_o,
    output logic             busy_o,
    output logic             stallreq_o
);

    localparam int unsigned MaxCnt = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCnt) + 1;
    localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;      // rj as latched
    logic [WIDTH-1:0] b_q, b_d;      // rk as latched
    logic [WIDTH-1:0] rem_q, rem_d;  // partial remainder
    logic [WIDTH-1:0] quo_q, quo_d;  // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_q, dvs_d;  // divisor magnitude
    logic [WIDTH-1:0] result_q, result_d;

    logic               accept;
    logic               in_signed;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic               mul_signed;
    logic [2*WIDTH-1:0] mul_a, mul_b, prod;
    logic [WIDTH-1:0]   mul_res;
    logic               div_signed;
    logic [WIDTH:0]     shifted, trial;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_next, quo_next;
    logic               neg_quo, neg_rem;
    logic [WIDTH-1:0]   div_res;

    // Operand magnitudes captured at accept; signed divides are DIV and MOD (op[1] = 0).
    always_comb begin
        accept    = (state_q == StIdle) && start_i && !cancel_i;
        in_signed = ~op_i[1];
        abs_a     = (in_signed && reg2_i[WIDTH-1]) ? (~reg2_i + One) : reg2_i;
        abs_b     = (in_signed && reg1_i[WIDTH-1]) ? (~reg1_i + One) : reg1_i;
    end

    // Multiply and divide datapaths working on the latched operands.
    always_comb begin
        // Only MULH is signed; the low half is the same for either signedness.
        mul_signed = (op_q[1:0] == 2'b01);
        mul_a      = {{WIDTH{mul_signed & a_q[WIDTH-1]}}, a_q};
        mul_b      = {{WIDTH{mul_signed & b_q[WIDTH-1]}}, b_q};
        prod       = mul_a * mul_b;
        // MULH (01) and MULHU (10) take the high half; MUL and reserved 011 take the low half.
        mul_res    = (op_q[1] ^ op_q[0]) ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];

        div_signed = ~op_q[1];
        shifted    = {rem_q, quo_q[WIDTH-1]};
        trial      = shifted - {1'b0, dvs_q};
        q_bit      = ~trial[WIDTH];
        rem_next   = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next   = {quo_q[WIDTH-2:0], q_bit};
        neg_quo    = div_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        neg_rem    = div_signed & a_q[WIDTH-1];

        // Divide by zero is fixed up explicitly: the magnitude loop does not produce it cleanly.
        if (b_q == '0) begin
            div_res = op_q[0] ? a_q : '1;
        end else if (op_q[0]) begin
            div_res = neg_rem ? (~rem_next + One) : rem_next;
        end else begin
            div_res = neg_quo ? (~quo_next + One) : quo_next;
        end
    end

    // Next-state logic: cancel beats start, start is only honoured in idle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        result_d = result_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d    = op_i;
                    a_d     = reg2_i;
                    b_d     = reg1_i;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = abs_a;
                    dvs_d   = abs_b;
                    state_d = op_i[2] ? StDiv : StMul;
                end
            end
            StMul: begin
                if (cancel_i) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(MUL_CYCLES - 1)) begin
                        result_d = mul_res;
                        state_d  = StDone;
                    end
                end
            end
            StDiv: begin
                if (cancel_i) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                    rem_d = rem_next;
                    quo_d = quo_next;
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        result_d = div_res;
                        state_d  = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
        end
    end

    assign result_o   = result_q;
    assign ready_o    = (state_q == StDone);
    assign busy_o     = (state_q == StMul) || (state_q == StDiv);
    // Low in the done cycle so the execute stage advances with the result.
    assign stallreq_o = accept || busy_o;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: a 32-bit instance (MUL_CYCLES=2) and a 16-bit
// instance (MUL_CYCLES=1). Cycle 0 is the cycle whose closing edge accepts the start.
module tb_ex_muldiv_unit;

    typedef struct {
        logic [31:0] res;
        int unsigned at;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cancel;
    logic        start32, start16;
    logic [2:0]  op32, op16;
    logic [31:0] r1_32, r2_32, res32;
    logic [15:0] r1_16, r2_16, res16;
    logic        rdy32, busy32, stall32;
    logic        rdy16, busy16, stall16;

    int unsigned cyc;
    int          checks   = 0;
    int          failures = 0;
    exp_t        q32[$];
    exp_t        q16[$];
    exp_t        e32, e16;
    logic [31:0] lr32 = '0;
    int unsigned c;

    ex_muldiv_unit #(.WIDTH(32), .MUL_CYCLES(2)) dut32 (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start32),
        .cancel_i   (cancel),
        .op_i       (op32),
        .reg1_i     (r1_32),
        .reg2_i     (r2_32),
        .result_o   (res32),
        .ready_o    (rdy32),
        .busy_o     (busy32),
        .stallreq_o (stall32)
    );

    ex_muldiv_unit #(.WIDTH(16), .MUL_CYCLES(1)) dut16 (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start16),
        .cancel_i   (cancel),
        .op_i       (op16),
        .reg1_i     (r1_16),
        .reg2_i     (r2_16),
        .result_o   (res16),
        .ready_o    (rdy16),
        .busy_o     (busy16),
        .stallreq_o (stall16)
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitors: pop one expectation per ready pulse, check value and arrival cycle.
    always @(negedge clk) begin
        if (rdy32 === 1'b1) begin
            if (q32.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready32: got ready_o=1 required 0 (cycle %0d)", cyc);
            end else begin
                e32 = q32.pop_front();
                check({e32.name, "_result"}, res32, e32.res);
                check({e32.name, "_cycle"}, cyc, e32.at);
                lr32 = e32.res;
            end
        end
    end

    always @(negedge clk) begin
        if (rdy16 === 1'b1) begin
            if (q16.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready16: got ready_o=1 required 0 (cycle %0d)", cyc);
            end else begin
                e16 = q16.pop_front();
                check({e16.name, "_result"}, {16'h0, res16}, e16.res);
                check({e16.name, "_cycle"}, cyc, e16.at);
            end
        end
    end

    task automatic wait_idle(input int inst);
        for (int k = 0; k < 200; k++) begin
            if (inst == 0 && !busy32 && !rdy32 && q32.size() == 0) return;
            if (inst == 1 && !busy16 && !rdy16 && q16.size() == 0) return;
            @(negedge clk);
        end
        checks++;
        failures++;
        $display("FAIL wait_idle%0d: got busy/pending after 200 cycles required idle", inst);
    endtask

    // Drive one start for a cycle; operands are scrambled afterwards since they are latched.
    task automatic issue(input int inst, input logic [2:0] op, input logic [31:0] r2,
                         input logic [31:0] r1, input logic [31:0] exp_res,
                         input int unsigned lat, input bit push, input string name,
                         output int unsigned c0);
        exp_t e;
        wait_idle(inst);
        c0 = cyc;
        if (inst == 0) begin
            start32 = 1'b1; op32 = op; r1_32 = r1; r2_32 = r2;
        end else begin
            start16 = 1'b1; op16 = op; r1_16 = r1[15:0]; r2_16 = r2[15:0];
        end
        if (push) begin
            e.res  = exp_res;
            e.at   = c0 + lat;
            e.name = name;
            if (inst == 0) q32.push_back(e);
            else           q16.push_back(e);
        end
        #1;
        check({name, "_stall_at_start"}, (inst == 0) ? stall32 : stall16, 32'd1);
        @(negedge clk);
        if (inst == 0) begin
            start32 = 1'b0; r1_32 = $urandom; r2_32 = $urandom;
        end else begin
            start16 = 1'b0; r1_16 = 16'($urandom); r2_16 = 16'($urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish required finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cancel = 1'b0;
        start32 = 1'b0; op32 = '0; r1_32 = '0; r2_32 = '0;
        start16 = 1'b0; op16 = '0; r1_16 = '0; r2_16 = '0;
        repeat (3) @(negedge clk);
        check("reset_result", res32, 32'h0);
        check("reset_ready", rdy32, 32'h0);
        check("reset_busy", busy32, 32'h0);
        check("reset_stall", stall32, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Signed divide with stall tracking across the whole operation.
        issue(0, 3'b100, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 33, 1, "div_m7_2", c);
        for (int k = 2; k <= 32; k++) begin
            @(negedge clk);
            check("div_stall_busy", stall32, 32'd1);
        end
        @(negedge clk);
        check("div_stall_ready_cycle", stall32, 32'd0);
        issue(0, 3'b101, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 33, 1, "mod_m7_2", c);
        issue(0, 3'b100, 32'h7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1, "div_7_m2", c);
        issue(0, 3'b101, 32'h7, 32'hFFFF_FFFE, 32'h1, 33, 1, "mod_7_m2", c);

        // Multiplies of -1 x -1 and signed/unsigned high halves.
        issue(0, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 3, 1, "mul_ff", c);
        issue(0, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 3, 1, "mulh_ff", c);
        issue(0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3, 1, "mulhu_ff", c);
        issue(0, 3'b001, 32'h8000_0000, 32'h2, 32'hFFFF_FFFF, 3, 1, "mulh_min_2", c);
        issue(0, 3'b010, 32'h8000_0000, 32'h2, 32'h1, 3, 1, "mulhu_min_2", c);
        issue(0, 3'b011, 32'h1234_5678, 32'h10, 32'h2345_6780, 3, 1, "mul_rsvd", c);

        // Boundary divides.
        issue(0, 3'b110, 32'h5, 32'h0, 32'hFFFF_FFFF, 33, 1, "divu_5_0", c);
        issue(0, 3'b111, 32'h5, 32'h0, 32'h5, 33, 1, "modu_5_0", c);
        issue(0, 3'b100, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFFF, 33, 1, "div_m7_0", c);
        issue(0, 3'b101, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 33, 1, "mod_m7_0", c);
        issue(0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 1, "div_ovf", c);
        issue(0, 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33, 1, "mod_ovf", c);
        issue(0, 3'b110, 32'd100, 32'd7, 32'd14, 33, 1, "divu_100_7", c);
        issue(0, 3'b111, 32'd100, 32'd7, 32'd2, 33, 1, "modu_100_7", c);

        // Cancel a divide mid-flight, then a multiply right behind it.
        issue(0, 3'b100, 32'd100, 32'd3, 32'h0, 0, 0, "div_cancel", c);
        while (cyc < c + 10) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", busy32, 32'd0);
        check("cancel_stall", stall32, 32'd0);
        check("cancel_result_hold", res32, lr32);
        issue(0, 3'b000, 32'd6, 32'd7, 32'd42, 3, 1, "mul_after_cancel", c);

        // Reset in the middle of a divide.
        issue(0, 3'b110, 32'd1000, 32'd9, 32'h0, 0, 0, "div_reset", c);
        while (cyc < c + 5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_result", res32, 32'h0);
        check("midrst_ready", rdy32, 32'h0);
        check("midrst_busy", busy32, 32'h0);

        // start_i held high: accepts at cycles 0, 4 and 8 with an idle gap each time.
        wait_idle(0);
        c = cyc;
        start32 = 1'b1; op32 = 3'b000; r1_32 = 32'd3; r2_32 = 32'd7;
        for (int k = 0; k < 3; k++) begin
            e32.res = 32'd21; e32.at = c + 3 + 4 * k; e32.name = "mul_held";
            q32.push_back(e32);
        end
        while (cyc < c + 9) @(negedge clk);
        start32 = 1'b0;

        // 16-bit instance.
        issue(1, 3'b110, 32'hFFFF, 32'h3, 32'h5555, 17, 1, "w16_divu", c);
        issue(1, 3'b010, 32'hFFFF, 32'hFFFF, 32'hFFFE, 2, 1, "w16_mulhu", c);
        issue(1, 3'b100, 32'h8000, 32'hFFFF, 32'h8000, 17, 1, "w16_div_ovf", c);
        issue(1, 3'b101, 32'h8000, 32'hFFFF, 32'h0, 17, 1, "w16_mod_ovf", c);

        wait_idle(0);
        wait_idle(1);
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
